// File: rtl/ghash_digit_serial_engine.sv
// Streaming GHASH engine: digit-serial GF(2^128) multiply, appends len(A)||len(C) and emits the tag.
// Define GHASH_TAG_MASK_EN to XOR the result with E(K,J0) (sampled with the last block).
module ghash_digit_serial_engine #(
  parameter int NB_DATA  = 128,
  parameter int NB_DIGIT = 8,
  parameter int NB_LEN   = 64
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_data_x,
  input  logic               i_valid,
  input  logic               i_last,
  input  logic [NB_DATA-1:0] i_h_key,
  input  logic [NB_LEN-1:0]  i_len_a,
  input  logic [NB_LEN-1:0]  i_len_c,
  input  logic [NB_DATA-1:0] i_ej0,
  output logic               o_ready,
  output logic [NB_DATA-1:0] o_tag,
  output logic               o_tag_valid
);

  localparam int D     = NB_DATA / NB_DIGIT;
  localparam int CNT_W = (D > 1) ? $clog2(D) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(D - 1);
  localparam logic [NB_DATA-1:0] R = {8'hE1, {(NB_DATA-8){1'b0}}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MULT = 2'd1;
  localparam logic [1:0] LEN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [NB_DATA-1:0] y, a, z, v, h, len_blk;
  logic               last;
  logic [NB_DATA-1:0] a_next, z_next, v_next;
  logic [NB_DATA-1:0] mask;

`ifdef GHASH_TAG_MASK_EN
  logic [NB_DATA-1:0] ej0;
  always_ff @(posedge i_clock) begin
    if (i_reset) ej0 <= '0;
    else if (state == IDLE && i_valid && i_last) ej0 <= i_ej0;
  end
  assign mask = ej0;
`else
  logic unused_ej0;
  assign unused_ej0 = ^i_ej0;
  assign mask = '0;
`endif

  // One digit of the right-shift multiply: operand bits leave a[] MSB first (x^0 first).
  always_comb begin
    a_next = a;
    z_next = z;
    v_next = v;
    for (int unsigned j = 0; j < NB_DIGIT; j++) begin
      if (a_next[NB_DATA-1]) z_next = z_next ^ v_next;
      v_next = v_next[0] ? ((v_next >> 1) ^ R) : (v_next >> 1);
      a_next = a_next << 1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state   <= IDLE;
      cnt     <= '0;
      y       <= '0;
      a       <= '0;
      z       <= '0;
      v       <= '0;
      h       <= '0;
      len_blk <= '0;
      last    <= 1'b0;
      o_tag   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            a     <= y ^ i_data_x;
            z     <= '0;
            v     <= i_h_key;
            h     <= i_h_key;
            last  <= i_last;
            cnt   <= '0;
            state <= MULT;
            if (i_last) len_blk <= {i_len_a, i_len_c};
          end
        end
        MULT: begin
          a <= a_next;
          z <= z_next;
          v <= v_next;
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            y   <= z_next;
            if (last) begin
              // Chain straight into the length block using the freshly finished Y.
              a     <= z_next ^ len_blk;
              z     <= '0;
              v     <= h;
              state <= LEN;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        LEN: begin
          a <= a_next;
          z <= z_next;
          v <= v_next;
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            y     <= z_next;
            o_tag <= z_next ^ mask;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          y     <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign o_ready     = (state == IDLE);
  assign o_tag_valid = (state == DONE);

endmodule

// File: tb/tb_ghash_digit_serial_engine.sv
// Scoreboard bench for ghash_digit_serial_engine, run at NB_DIGIT=8 and NB_DIGIT=128 side by side.
// Honours GHASH_TAG_MASK_EN when it is defined for the build.
module tb_ghash_digit_serial_engine;

`ifdef GHASH_TAG_MASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif

  localparam logic [127:0] H1   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] X1   = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] EJ1  = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] T1   = MASK ? 128'hab6e47d42cec13bdf53a67b21257bddf
                                       : 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
  localparam logic [127:0] H3   = 128'hb83b533708bf535d0aa6e52980d53b78;
  localparam logic [127:0] G3   = 128'h7f1b32b81b820d02614f8895ac1d4eac;
  localparam logic [127:0] B3_0 = 128'h42831ec2217774244b7221b784d0d49c;
  localparam logic [127:0] B3_1 = 128'he3aa212f2c02a4e035c17e2329aca12e;
  localparam logic [127:0] B3_2 = 128'h21d514b25466931c7d8f6a5aac84aa05;
  localparam logic [127:0] B3_3 = 128'h1ba30b396a0aac973d58e091473f5985;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int dg, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (NB_DIGIT=%0d): got %h, expected %h", name, dg, act, exp);
    end
  endtask

  task automatic flag(input string name, input int dg);
    vectors++;
    miscompares++;
    $display("FAIL %s (NB_DIGIT=%0d): got event, expected none", name, dg);
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int DG = (g == 0) ? 8 : 128;
    localparam int D  = 128 / DG;

    typedef struct {
      logic [127:0] tag;
      int           at_edge;
    } exp_t;

    logic         rst, valid, last, ready, tag_valid;
    logic [127:0] data, h, ej0, tag;
    logic [63:0]  len_a, len_c;
    int           ecount = 0;
    bit           fin = 1'b0;
    exp_t         sb[$];

    always @(posedge clk) ecount++;

    ghash_digit_serial_engine #(.NB_DATA(128), .NB_DIGIT(DG), .NB_LEN(64)) dut (
      .i_clock(clk), .i_reset(rst), .i_data_x(data), .i_valid(valid), .i_last(last),
      .i_h_key(h), .i_len_a(len_a), .i_len_c(len_c), .i_ej0(ej0),
      .o_ready(ready), .o_tag(tag), .o_tag_valid(tag_valid)
    );

    always @(negedge clk) begin
      if (tag_valid === 1'b1) begin
        if (sb.size() == 0) begin
          flag("spurious_tag_valid", DG);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("tag", DG, tag, e.tag);
          check("tag_edge", DG, 128'(ecount), 128'(e.at_edge));
        end
      end
    end

    // Called at a negedge; returns at the negedge where o_ready is back high.
    task automatic send(input logic [127:0] x, input logic lst, input logic [127:0] expd, input bit garbage);
      int wt, acc, busy;
      logic [127:0] keep_ej0;
      keep_ej0 = ej0;
      valid = 1'b1;
      data  = x;
      last  = lst;
      wt = 0;
      while (ready !== 1'b1 && wt < 100) begin
        wt++;
        @(negedge clk);
      end
      if (wt >= 100) flag("ready_timeout", DG);
      @(posedge clk);
      @(negedge clk);
      acc = ecount;
      if (lst) sb.push_back('{tag: expd, at_edge: acc + 2 * D});
      busy = 0;
      while (ready !== 1'b1 && busy < 100) begin
        busy++;
        if (garbage) begin
          valid = 1'($urandom_range(0, 1));
          data  = {$urandom(), $urandom(), $urandom(), $urandom()};
          last  = 1'($urandom_range(0, 1));
          ej0   = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        @(negedge clk);
      end
      check(lst ? "busy_cycles_last" : "busy_cycles", DG, 128'(busy), lst ? 128'(2 * D + 1) : 128'(D));
      valid = 1'b0;
      last  = 1'b0;
      ej0   = keep_ej0;
    endtask

    task automatic run_t1(input bit garbage);
      h = H1; len_a = '0; len_c = 64'd128; ej0 = EJ1;
      send(X1, 1'b1, T1, garbage);
    endtask

    task automatic run_t3();
      logic [127:0] m;
      h = H3; len_a = '0; len_c = 64'd512;
      m = {$urandom(), $urandom(), $urandom(), $urandom()};
      ej0 = m;
      send(B3_0, 1'b0, '0, 1'b0);
      send(B3_1, 1'b0, '0, 1'b0);
      send(B3_2, 1'b0, '0, 1'b0);
      send(B3_3, 1'b1, MASK ? (G3 ^ m) : G3, 1'b0);
    endtask

    initial begin
      int wt;
      rst = 1'b1; valid = 1'b0; last = 1'b0; data = '0; h = '0; ej0 = '0; len_a = '0; len_c = '0;
      repeat (2) @(negedge clk);
      check("reset_ready", DG, 128'(ready), 128'(1));
      check("reset_tag", DG, tag, '0);
      check("reset_tag_valid", DG, 128'(tag_valid), 128'(0));
      rst = 1'b0;
      @(negedge clk);

      run_t1(1'b0);
      run_t1(1'b1);
      run_t1(1'b0);
      run_t3();
      repeat (3) @(negedge clk);
      run_t3();

      // Reset lands on edge 2 counted from the second block's accept.
      h = H3; len_a = '0; len_c = 64'd512;
      send(B3_0, 1'b0, '0, 1'b0);
      valid = 1'b1; data = B3_1; last = 1'b0;
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midop_reset_ready", DG, 128'(ready), 128'(1));
      check("midop_reset_tag", DG, tag, '0);
      check("midop_reset_tag_valid", DG, 128'(tag_valid), 128'(0));

      run_t1(1'b0);
      repeat (4) @(negedge clk);
      wt = 0;
      while (sb.size() != 0 && wt < 100) begin
        wt++;
        @(negedge clk);
      end
      check("scoreboard_drained", DG, 128'(sb.size()), 128'(0));
      fin = 1'b1;
    end
  end

  initial begin
    int wt;
    wt = 0;
    while (!(u[0].fin && u[1].fin) && wt < 20000) begin
      wt++;
      @(negedge clk);
    end
    if (wt >= 20000) begin
      vectors++;
      miscompares++;
      $display("FAIL run_timeout: got unfinished run, expected both instances done");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
